pkt_block_allocator: RTL and testbench
======================================

# pkt_block_allocator

Parametrised first-fit allocator for the packet SRAM. It maintains an address-ordered doubly linked list of memory blocks in an internal node table, and serves one request at a time. An allocate request splits a free block, and a free request releases a block and coalesces it with free neighbours. It sits between the ingress write controller, which allocates, and the egress read controller, which frees, and replaces the fixed 512-node/12-bit allocator with a handshaked, multi-cycle, width-generic engine.

## Interface
- MEM_UNITS, 4096: total allocatable units; block addresses/sizes are in units.
- ADDR_W, 12: address width; 2^ADDR_W ≥ MEM_UNITS.
- SIZE_W, 13: size field width; must represent MEM_UNITS.
- REQ_W, 8: alloc_size width.
- NODES, 64: node-table depth (max simultaneous blocks).
- ID_W, 7: node index width; 2^ID_W > NODES. NULL = all-ones of ID_W.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  idle; requests sampled only when high.
- alloc_req  in  1  allocate request.
- alloc_size  in  REQ_W  requested units.
- alloc_done  out  1  one-cycle completion pulse.
- alloc_ok  out  1  valid with alloc_done; 0 = failure.
- alloc_addr  out  ADDR_W  start address of granted block.
- alloc_id  out  ID_W  node id of granted block; used later to free it.
- free_req  in  1  free request.
- free_id  in  ID_W  node id to release.
- free_done  out  1  one-cycle completion pulse.
- free_err  out  1  valid with free_done; invalid id, no state change.
- free_units  out  SIZE_W  total free units.
- nodes_used  out  ID_W  node-table entries in use.

## Operation
- Node fields: start[ADDR_W], size[SIZE_W], busy, valid, prev[ID_W], next[ID_W]. Register `head` points to the lowest-address node. A free-node pool bitmap marks the table entries that are not valid.
- Reset state: node 0 = {start 0, size MEM_UNITS, busy 0, valid 1, prev NULL, next NULL}; all other nodes invalid; head=0; free_units=MEM_UNITS; nodes_used=1; ready=1; all done/ok/err outputs 0; alloc_addr and alloc_id 0.
- FSM states: IDLE, A_WALK, A_DONE, F_CHK_NEXT, F_CHK_PREV, F_DONE.
- IDLE:
  - alloc_req and free_req both high: the free request is accepted, and the alloc request is ignored. The requester must re-request.
  - Accepting a request latches its inputs and drops ready.
- Allocate, A_WALK: visits one node per cycle, starting at head.
  - Hit = valid, !busy, size ≥ alloc_size.
  - Exact fit: set busy, return this id.
  - Larger fit: take the lowest-index free table entry n.
    - n = {start=cur.start, size=alloc_size, busy 1, prev=cur.prev, next=cur}.
    - cur.start += alloc_size; cur.size −= alloc_size; cur.prev = n.
    - cur.prev.next = n, or head = n if cur was head. Return n.
- Allocate failure (alloc_ok=0, nothing modified) occurs when:
  - alloc_size = 0;
  - the walk reaches NULL without a hit;
  - a split is needed and the table is full. In this case the walk does not continue past the fitting node.
- Free:
  - Invalid id (≥NODES, not valid, or not busy) → F_DONE with free_err=1.
  - Otherwise, set busy=0 and free_units += size.
  - F_CHK_NEXT: if next is valid and free, absorb it (size sum, relink, invalidate it).
  - F_CHK_PREV: if prev is free, prev absorbs the current node likewise.
- free_units and nodes_used update in the same cycle as the table write that changes them.
- Reset mid-operation discards the request with no done pulse, and the table returns to its reset state.

## Timing
- Request accepted on edge T.
- A_WALK visits the k-th list node (k=0 at head) in cycle T+1+k. The table update occurs at the end of the hit cycle. alloc_done is high in cycle T+2+k.
- A failed walk over L nodes: alloc_done in cycle T+2+L (or T+2+k on table-full).
- Free: F_CHK_NEXT in T+1, F_CHK_PREV in T+2, free_done in T+3. Invalid free: free_done in T+1.
- ready returns high in the done cycle, and a new request is accepted on the edge ending it.
- Outputs are registered. alloc_addr and alloc_id hold until the next alloc_done.

## Test plan
- After reset: alloc 64 → done at T+2, ok=1, addr=0, id=1, free_units=4032, nodes_used=2.
- Allocs 64, 128, 32 → addrs 0, 64, 192. Then free the 128-block id → free_done at T+3, free_units increases by 128, nodes_used unchanged (no free neighbour).
- Continue from the previous scenario: alloc 128 → exact fit reuses that id at addr 64, with no split and nodes_used unchanged.
- Free the middle block, then the first, then the last → full coalescing back to a single node: start 0, size 4096, nodes_used=1.
- Failure cases, each with nothing modified:
  - alloc 0 → ok=0;
  - fill all 4096 units with 64-unit blocks, then alloc 1 → ok=0;
  - with NODES=4, a 4th split → ok=0.
- Free of an already-free id → free_err=1 at T+1. Simultaneous alloc_req/free_req → only the free completes. rst asserted during A_WALK → reset state, no done pulse.

Source files
------------

// File: rtl/pkt_block_allocator_if.sv
// rtl/pkt_block_allocator_if.sv - request/response bundle between the SRAM controllers and the block allocator
interface pkt_block_allocator_if #(
    parameter int ADDR_W = 12,
    parameter int SIZE_W = 13,
    parameter int REQ_W  = 8,
    parameter int ID_W   = 7
);
    logic              ready;
    logic              alloc_req;
    logic [REQ_W-1:0]  alloc_size;
    logic              alloc_done;
    logic              alloc_ok;
    logic [ADDR_W-1:0] alloc_addr;
    logic [ID_W-1:0]   alloc_id;
    logic              free_req;
    logic [ID_W-1:0]   free_id;
    logic              free_done;
    logic              free_err;
    logic [SIZE_W-1:0] free_units;
    logic [ID_W-1:0]   nodes_used;

    // Requester side: ingress/egress controllers.
    modport master (
        input  ready, alloc_done, alloc_ok, alloc_addr, alloc_id,
               free_done, free_err, free_units, nodes_used,
        output alloc_req, alloc_size, free_req, free_id
    );

    // Allocator side.
    modport slave (
        output ready, alloc_done, alloc_ok, alloc_addr, alloc_id,
               free_done, free_err, free_units, nodes_used,
        input  alloc_req, alloc_size, free_req, free_id
    );
endinterface

// File: rtl/pkt_block_allocator.sv
// rtl/pkt_block_allocator.sv - first-fit packet SRAM block allocator over an address-ordered linked node table
module pkt_block_allocator #(
    parameter int MEM_UNITS = 4096,
    parameter int ADDR_W    = 12,
    parameter int SIZE_W    = 13,
    parameter int REQ_W     = 8,
    parameter int NODES     = 64,
    parameter int ID_W      = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    pkt_block_allocator_if.slave bus
);
    // Table index width; ids are wider so that NULL (all ones) never aliases a real entry.
    localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;
    localparam logic [ID_W-1:0] NULL_ID  = '1;
    localparam logic [ID_W-1:0] NODES_ID = ID_W'(NODES);

    typedef enum logic [2:0] {
        IDLE,
        A_WALK,
        A_DONE,
        F_CHK_NEXT,
        F_CHK_PREV,
        F_DONE
    } state_t;

    state_t            state_q;

    // Node table, one entry per block.
    logic [ADDR_W-1:0] start_q [NODES];
    logic [SIZE_W-1:0] size_q  [NODES];
    logic [ID_W-1:0]   prev_q  [NODES];
    logic [ID_W-1:0]   next_q  [NODES];
    logic [NODES-1:0]  busy_q;
    logic [NODES-1:0]  valid_q;

    logic [ID_W-1:0]   head_q;
    logic [ID_W-1:0]   cur_q;
    logic [REQ_W-1:0]  req_size_q;

    logic              ready_q;
    logic              alloc_done_q;
    logic              alloc_ok_q;
    logic [ADDR_W-1:0] alloc_addr_q;
    logic [ID_W-1:0]   alloc_id_q;
    logic              free_done_q;
    logic              free_err_q;
    logic [SIZE_W-1:0] free_units_q;
    logic [ID_W-1:0]   nodes_used_q;

    // Views of the node under the cursor and its neighbours.
    logic [IDX_W-1:0]  cur_ix, nx_ix, nn_ix, pv_ix, fid_ix, pool_ix;
    logic [ADDR_W-1:0] cur_start;
    logic [SIZE_W-1:0] cur_size, req_ext;
    logic [ID_W-1:0]   cur_prev, cur_next, nn_id, pool_id;
    logic              cur_ok, cur_hit, cur_exact;
    logic              nx_free, nn_ok, pv_free, next_ok, fid_ok, pool_full;

    assign cur_ix    = cur_q[IDX_W-1:0];
    assign cur_ok    = (cur_q < NODES_ID) && valid_q[cur_ix];
    assign cur_start = start_q[cur_ix];
    assign cur_size  = size_q[cur_ix];
    assign cur_prev  = prev_q[cur_ix];
    assign cur_next  = next_q[cur_ix];
    assign req_ext   = SIZE_W'(req_size_q);
    assign cur_hit   = cur_ok && !busy_q[cur_ix] && (cur_size >= req_ext);
    assign cur_exact = (cur_size == req_ext);

    assign nx_ix     = cur_next[IDX_W-1:0];
    assign next_ok   = (cur_next < NODES_ID);
    assign nx_free   = next_ok && valid_q[nx_ix] && !busy_q[nx_ix];
    assign nn_id     = next_q[nx_ix];
    assign nn_ix     = nn_id[IDX_W-1:0];
    assign nn_ok     = (nn_id < NODES_ID);

    assign pv_ix     = cur_prev[IDX_W-1:0];
    assign pv_free   = (cur_prev < NODES_ID) && valid_q[pv_ix] && !busy_q[pv_ix];

    assign fid_ix    = bus.free_id[IDX_W-1:0];
    assign fid_ok    = (bus.free_id < NODES_ID) && valid_q[fid_ix] && busy_q[fid_ix];

    assign pool_full = &valid_q;
    assign pool_ix   = pool_id[IDX_W-1:0];

    // Lowest-index unused table entry, taken by a split.
    always_comb begin
        pool_id = NULL_ID;
        for (int i = NODES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                pool_id = ID_W'(i);
            end
        end
    end

    // Request FSM: list walk, split, release and coalescing, with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) begin
                start_q[i] <= '0;
                size_q[i]  <= '0;
                prev_q[i]  <= NULL_ID;
                next_q[i]  <= NULL_ID;
            end
            size_q[0]    <= SIZE_W'(MEM_UNITS);
            busy_q       <= '0;
            valid_q      <= NODES'(1);
            head_q       <= '0;
            cur_q        <= '0;
            req_size_q   <= '0;
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            alloc_done_q <= 1'b0;
            alloc_ok_q   <= 1'b0;
            alloc_addr_q <= '0;
            alloc_id_q   <= '0;
            free_done_q  <= 1'b0;
            free_err_q   <= 1'b0;
            free_units_q <= SIZE_W'(MEM_UNITS);
            nodes_used_q <= ID_W'(1);
        end else begin
            alloc_done_q <= 1'b0;
            alloc_ok_q   <= 1'b0;
            free_done_q  <= 1'b0;
            free_err_q   <= 1'b0;
            case (state_q)
                A_WALK: begin
                    if (req_size_q == '0 || !cur_ok) begin
                        // Zero-size request or end of list: fail untouched.
                        alloc_done_q <= 1'b1;
                        ready_q      <= 1'b1;
                        state_q      <= A_DONE;
                    end else if (cur_hit) begin
                        alloc_done_q <= 1'b1;
                        ready_q      <= 1'b1;
                        state_q      <= A_DONE;
                        if (cur_exact) begin
                            busy_q[cur_ix] <= 1'b1;
                            free_units_q   <= free_units_q - cur_size;
                            alloc_ok_q     <= 1'b1;
                            alloc_addr_q   <= cur_start;
                            alloc_id_q     <= cur_q;
                        end else if (!pool_full) begin
                            // New node takes the low part; the cursor keeps the remainder.
                            start_q[pool_ix] <= cur_start;
                            size_q[pool_ix]  <= req_ext;
                            busy_q[pool_ix]  <= 1'b1;
                            valid_q[pool_ix] <= 1'b1;
                            prev_q[pool_ix]  <= cur_prev;
                            next_q[pool_ix]  <= cur_q;
                            start_q[cur_ix]  <= cur_start + ADDR_W'(req_size_q);
                            size_q[cur_ix]   <= cur_size - req_ext;
                            prev_q[cur_ix]   <= pool_id;
                            if (cur_prev < NODES_ID) begin
                                next_q[pv_ix] <= pool_id;
                            end else begin
                                head_q <= pool_id;
                            end
                            free_units_q <= free_units_q - req_ext;
                            nodes_used_q <= nodes_used_q + ID_W'(1);
                            alloc_ok_q   <= 1'b1;
                            alloc_addr_q <= cur_start;
                            alloc_id_q   <= pool_id;
                        end
                    end else begin
                        cur_q <= cur_next;
                    end
                end
                F_CHK_NEXT: begin
                    // Absorb a free successor into the released block.
                    if (nx_free) begin
                        size_q[cur_ix]  <= cur_size + size_q[nx_ix];
                        next_q[cur_ix]  <= nn_id;
                        if (nn_ok) begin
                            prev_q[nn_ix] <= cur_q;
                        end
                        valid_q[nx_ix]  <= 1'b0;
                        nodes_used_q    <= nodes_used_q - ID_W'(1);
                    end
                    state_q <= F_CHK_PREV;
                end
                F_CHK_PREV: begin
                    // A free predecessor absorbs the released block.
                    if (pv_free) begin
                        size_q[pv_ix]   <= size_q[pv_ix] + cur_size;
                        next_q[pv_ix]   <= cur_next;
                        if (next_ok) begin
                            prev_q[nx_ix] <= cur_prev;
                        end
                        valid_q[cur_ix] <= 1'b0;
                        nodes_used_q    <= nodes_used_q - ID_W'(1);
                    end
                    free_done_q <= 1'b1;
                    ready_q     <= 1'b1;
                    state_q     <= F_DONE;
                end
                default: begin
                    // IDLE and the done cycles accept a new request; free wins over alloc.
                    if (bus.free_req) begin
                        if (fid_ok) begin
                            busy_q[fid_ix] <= 1'b0;
                            free_units_q   <= free_units_q + size_q[fid_ix];
                            cur_q          <= bus.free_id;
                            ready_q        <= 1'b0;
                            state_q        <= F_CHK_NEXT;
                        end else begin
                            free_done_q <= 1'b1;
                            free_err_q  <= 1'b1;
                            ready_q     <= 1'b1;
                            state_q     <= F_DONE;
                        end
                    end else if (bus.alloc_req) begin
                        req_size_q <= bus.alloc_size;
                        cur_q      <= head_q;
                        ready_q    <= 1'b0;
                        state_q    <= A_WALK;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.alloc_done = alloc_done_q;
    assign bus.alloc_ok   = alloc_ok_q;
    assign bus.alloc_addr = alloc_addr_q;
    assign bus.alloc_id   = alloc_id_q;
    assign bus.free_done  = free_done_q;
    assign bus.free_err   = free_err_q;
    assign bus.free_units = free_units_q;
    assign bus.nodes_used = nodes_used_q;

endmodule

// File: tb/tb_pkt_block_allocator.sv
// tb/tb_pkt_block_allocator.sv - self-checking bench for pkt_block_allocator against a block-list model
module tb_pkt_block_allocator;
    localparam int NODES = 64;
    localparam int MEM   = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pkt_block_allocator_if #(.ADDR_W(12), .SIZE_W(13), .REQ_W(8), .ID_W(7)) bus ();
    pkt_block_allocator_if #(.ADDR_W(12), .SIZE_W(13), .REQ_W(8), .ID_W(3)) bus4 ();

    pkt_block_allocator #(.MEM_UNITS(MEM), .ADDR_W(12), .SIZE_W(13), .REQ_W(8), .NODES(NODES), .ID_W(7))
        dut (.clk(clk), .rst(rst), .bus(bus));
    pkt_block_allocator #(.MEM_UNITS(MEM), .ADDR_W(12), .SIZE_W(13), .REQ_W(8), .NODES(4), .ID_W(3))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        int start;
        int size;
        bit busy;
        int id;
    } blk_t;

    blk_t mq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        blk_t b;
        mq.delete();
        b.start = 0; b.size = MEM; b.busy = 0; b.id = 0;
        mq.push_back(b);
    endtask

    function automatic int lowest_free_id();
        bit used;
        for (int i = 0; i < NODES; i++) begin
            used = 0;
            foreach (mq[j]) if (mq[j].id == i) used = 1;
            if (!used) return i;
        end
        return -1;
    endfunction

    function automatic int model_fu();
        int s;
        s = 0;
        foreach (mq[j]) if (!mq[j].busy) s += mq[j].size;
        return s;
    endfunction

    // First fit over the address-ordered block list; lat = edges from acceptance to done.
    task automatic model_alloc(input int sz, output bit ok, output int addr, output int id, output int lat);
        blk_t b;
        ok = 0; addr = 0; id = 0; lat = -1;
        if (sz == 0) return;
        for (int k = 0; k < mq.size(); k++) begin
            if (!mq[k].busy && mq[k].size >= sz) begin
                lat = k + 1;
                if (mq[k].size == sz) begin
                    mq[k].busy = 1; ok = 1; addr = mq[k].start; id = mq[k].id;
                end else if (mq.size() < NODES) begin
                    b.start = mq[k].start; b.size = sz; b.busy = 1; b.id = lowest_free_id();
                    mq[k].start += sz;
                    mq[k].size -= sz;
                    mq.insert(k, b);
                    ok = 1; addr = b.start; id = b.id;
                end
                return;
            end
        end
        lat = mq.size() + 1;
    endtask

    task automatic model_free(input int id, output bit err, output int lat);
        int p;
        p = -1;
        foreach (mq[j]) if (mq[j].id == id) p = j;
        if (p < 0 || !mq[p].busy) begin
            err = 1; lat = 0;
            return;
        end
        err = 0; lat = 2;
        mq[p].busy = 0;
        if (p + 1 < mq.size() && !mq[p+1].busy) begin
            mq[p].size += mq[p+1].size;
            mq.delete(p + 1);
        end
        if (p > 0 && !mq[p-1].busy) begin
            mq[p-1].size += mq[p].size;
            mq.delete(p);
        end
    endtask

    // Drive one request from a post-edge point and wait (bounded) for the matching done.
    task automatic issue(input bit a, input bit f, input int sz, input int id, output int lat, output int a_seen);
        chk("ready_before_req", bus.ready, 1);
        bus.alloc_req  = a;
        bus.free_req   = f;
        bus.alloc_size = 8'(sz);
        bus.free_id    = 7'(id);
        @(posedge clk); #1;
        bus.alloc_req = 0;
        bus.free_req  = 0;
        lat = 0;
        a_seen = 0;
        while (!(f ? bus.free_done : bus.alloc_done) && lat < 200) begin
            if (bus.alloc_done) a_seen++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.alloc_done) a_seen++;
    endtask

    task automatic do_alloc(input int sz);
        bit eok; int eaddr, eid, elat, lat, as;
        model_alloc(sz, eok, eaddr, eid, elat);
        issue(1, 0, sz, 0, lat, as);
        chk("alloc_done", bus.alloc_done, 1);
        if (elat >= 0) chk("alloc_latency", lat, elat);
        chk("alloc_ok", bus.alloc_ok, eok);
        if (eok) begin
            chk("alloc_addr", bus.alloc_addr, eaddr);
            chk("alloc_id", bus.alloc_id, eid);
        end
        chk("alloc_ready", bus.ready, 1);
        chk("alloc_free_units", bus.free_units, model_fu());
        chk("alloc_nodes_used", bus.nodes_used, mq.size());
    endtask

    task automatic do_free(input int id, input bit with_alloc);
        bit eerr; int elat, lat, as;
        model_free(id, eerr, elat);
        issue(with_alloc, 1, 10, id, lat, as);
        chk("free_done", bus.free_done, 1);
        chk("free_latency", lat, elat);
        chk("free_err", bus.free_err, eerr);
        chk("free_ready", bus.ready, 1);
        chk("free_free_units", bus.free_units, model_fu());
        chk("free_nodes_used", bus.nodes_used, mq.size());
        if (with_alloc) chk("simul_alloc_ignored", as, 0);
    endtask

    task automatic alloc4(input int sz, input bit eok, input int enu);
        int lat;
        bus4.alloc_req  = 1;
        bus4.alloc_size = 8'(sz);
        @(posedge clk); #1;
        bus4.alloc_req = 0;
        lat = 0;
        while (!bus4.alloc_done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("n4_done", bus4.alloc_done, 1);
        chk("n4_ok", bus4.alloc_ok, eok);
        chk("n4_nodes_used", bus4.nodes_used, enu);
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        int pulses, r, bl[$];
        bus.alloc_req = 0; bus.alloc_size = 0; bus.free_req = 0; bus.free_id = 0;
        bus4.alloc_req = 0; bus4.alloc_size = 0; bus4.free_req = 0; bus4.free_id = 0;
        do_reset();

        // Reset state
        chk("rst_ready", bus.ready, 1);
        chk("rst_free_units", bus.free_units, MEM);
        chk("rst_nodes_used", bus.nodes_used, 1);
        chk("rst_alloc_done", bus.alloc_done, 0);
        chk("rst_alloc_ok", bus.alloc_ok, 0);
        chk("rst_free_done", bus.free_done, 0);
        chk("rst_free_err", bus.free_err, 0);
        chk("rst_alloc_addr", bus.alloc_addr, 0);
        chk("rst_alloc_id", bus.alloc_id, 0);

        // Small table: the fourth split finds no free entry
        alloc4(16, 1, 2);
        alloc4(16, 1, 3);
        alloc4(16, 1, 4);
        alloc4(16, 0, 4);
        chk("n4_free_units", bus4.free_units, MEM - 48);

        // Basic splits, release without neighbours, exact-fit reuse
        do_alloc(64);
        do_alloc(128);
        do_alloc(32);
        do_free(2, 0);
        do_alloc(128);
        // Full coalescing: middle, first, last
        do_free(2, 0);
        do_free(1, 0);
        do_free(3, 0);
        chk("coalesced_nodes", bus.nodes_used, 1);
        chk("coalesced_units", bus.free_units, MEM);
        do_alloc(0);
        do_free(1, 0);
        do_free(100, 0);
        do_alloc(255);
        do_free(0, 1);

        // Fill the memory with 64-unit blocks, then one more unit fails
        do_reset();
        for (int i = 0; i < MEM / 64; i++) do_alloc(64);
        do_alloc(1);

        // Reset during a long walk
        bus.alloc_req = 1; bus.alloc_size = 1;
        @(posedge clk); #1;
        bus.alloc_req = 0;
        pulses = 0;
        repeat (10) begin
            if (bus.alloc_done) pulses++;
            @(posedge clk); #1;
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        repeat (3) begin
            if (bus.alloc_done) pulses++;
            @(posedge clk); #1;
        end
        chk("rst_walk_no_done", pulses, 0);
        chk("rst_walk_ready", bus.ready, 1);
        chk("rst_walk_free_units", bus.free_units, MEM);
        chk("rst_walk_nodes_used", bus.nodes_used, 1);
        chk("rst_walk_alloc_addr", bus.alloc_addr, 0);
        do_alloc(64);

        // Randomised mix against the model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                do_alloc($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 255));
            end else if (r < 90) begin
                bl.delete();
                foreach (mq[j]) if (mq[j].busy) bl.push_back(mq[j].id);
                if (bl.size() > 0) do_free(bl[$urandom_range(0, bl.size() - 1)], 0);
                else do_alloc($urandom_range(1, 255));
            end else begin
                do_free($urandom_range(0, 127), $urandom_range(0, 1) == 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
